// File: rtl/matmul_sequencer.sv
// Address/strobe sequencer for a single-MAC matrix multiply: walks A rows against
// B columns, paces the MAC one cycle behind the SRAM reads, and strobes each result.
module matmul_sequencer #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DIM_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    output logic [ADDR_W-1:0]    a_raddr,
    output logic [ADDR_W-1:0]    b_raddr,
    input  logic [2*DIM_W-1:0]   a_rdata_hdr,
    input  logic [2*DIM_W-1:0]   b_rdata_hdr,
    output logic                 mac_clear,
    output logic                 mac_acc_en,
    output logic                 res_we,
    output logic [ADDR_W-1:0]    res_waddr,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned HDR_W = 2 * DIM_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RUN,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [DIM_W-1:0]    m_dim, m_dim_n;
    logic [DIM_W-1:0]    k_dim, k_dim_n;
    logic [DIM_W-1:0]    n_dim, n_dim_n;
    logic [DIM_W-1:0]    i_cnt, i_cnt_n;
    logic [DIM_W-1:0]    j_cnt, j_cnt_n;
    logic [DIM_W-1:0]    k_cnt, k_cnt_n;
    logic [ADDR_W-1:0]   a_base, a_base_n;
    logic [ADDR_W-1:0]   b_base, b_base_n;
    logic [ADDR_W-1:0]   res_cnt, res_cnt_n;

    logic                start_ready_n;
    logic [ADDR_W-1:0]   a_raddr_n, b_raddr_n, res_waddr_n;
    logic                mac_clear_n, mac_acc_en_n, res_we_n, done_n, err_n;

    logic [DIM_W-1:0]    hdr_m, hdr_k, hdr_kb, hdr_n;
    logic                hdr_bad;

    assign hdr_m   = a_rdata_hdr[HDR_W-1:DIM_W];
    assign hdr_k   = a_rdata_hdr[DIM_W-1:0];
    assign hdr_kb  = b_rdata_hdr[HDR_W-1:DIM_W];
    assign hdr_n   = b_rdata_hdr[DIM_W-1:0];
    assign hdr_bad = (hdr_m == '0) || (hdr_k == '0) || (hdr_n == '0) || (hdr_kb != hdr_k);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            m_dim       <= '0;
            k_dim       <= '0;
            n_dim       <= '0;
            i_cnt       <= '0;
            j_cnt       <= '0;
            k_cnt       <= '0;
            a_base      <= '0;
            b_base      <= '0;
            res_cnt     <= '0;
            start_ready <= 1'b1;
            a_raddr     <= '0;
            b_raddr     <= '0;
            res_waddr   <= '0;
            mac_clear   <= 1'b0;
            mac_acc_en  <= 1'b0;
            res_we      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            m_dim       <= m_dim_n;
            k_dim       <= k_dim_n;
            n_dim       <= n_dim_n;
            i_cnt       <= i_cnt_n;
            j_cnt       <= j_cnt_n;
            k_cnt       <= k_cnt_n;
            a_base      <= a_base_n;
            b_base      <= b_base_n;
            res_cnt     <= res_cnt_n;
            start_ready <= start_ready_n;
            a_raddr     <= a_raddr_n;
            b_raddr     <= b_raddr_n;
            res_waddr   <= res_waddr_n;
            mac_clear   <= mac_clear_n;
            mac_acc_en  <= mac_acc_en_n;
            res_we      <= res_we_n;
            done        <= done_n;
            err         <= err_n;
        end
    end

    // Next state; outputs are computed one cycle ahead so they appear registered in the target state
    always_comb begin
        state_n       = state;
        m_dim_n       = m_dim;
        k_dim_n       = k_dim;
        n_dim_n       = n_dim;
        i_cnt_n       = i_cnt;
        j_cnt_n       = j_cnt;
        k_cnt_n       = k_cnt;
        a_base_n      = a_base;
        b_base_n      = b_base;
        res_cnt_n     = res_cnt;
        start_ready_n = 1'b0;
        a_raddr_n     = '0;
        b_raddr_n     = '0;
        res_waddr_n   = res_waddr;
        mac_clear_n   = 1'b0;
        mac_acc_en_n  = 1'b0;
        res_we_n      = 1'b0;
        done_n        = 1'b0;
        err_n         = err;

        case (state)
            S_IDLE: begin
                start_ready_n = 1'b1;
                if (start_valid && start_ready) begin
                    state_n       = S_HDR;
                    start_ready_n = 1'b0;
                    err_n         = 1'b0;
                end
            end

            S_HDR: begin
                m_dim_n = hdr_m;
                k_dim_n = hdr_k;
                n_dim_n = hdr_n;
                if (hdr_bad) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    state_n   = S_RUN;
                    i_cnt_n   = '0;
                    j_cnt_n   = '0;
                    k_cnt_n   = '0;
                    a_base_n  = ADDR_W'(1);
                    b_base_n  = ADDR_W'(1);
                    res_cnt_n = '0;
                    a_raddr_n = ADDR_W'(1);
                    b_raddr_n = ADDR_W'(1);
                end
            end

            S_RUN: begin
                mac_acc_en_n = 1'b1;
                mac_clear_n  = (k_cnt == '0);
                if (k_cnt == k_dim - DIM_W'(1)) begin
                    state_n = S_LAST;
                end else begin
                    k_cnt_n   = k_cnt + DIM_W'(1);
                    a_raddr_n = a_raddr + ADDR_W'(1);
                    b_raddr_n = b_raddr + ADDR_W'(1);
                end
            end

            S_LAST: begin
                state_n     = S_WRITE;
                res_we_n    = 1'b1;
                res_waddr_n = res_cnt;
            end

            S_WRITE: begin
                k_cnt_n   = '0;
                res_cnt_n = res_cnt + ADDR_W'(1);
                if ((i_cnt == m_dim - DIM_W'(1)) && (j_cnt == n_dim - DIM_W'(1))) begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end else begin
                    // Bases advance by K per step so no multiplier sits on the address path
                    if (j_cnt == n_dim - DIM_W'(1)) begin
                        j_cnt_n  = '0;
                        i_cnt_n  = i_cnt + DIM_W'(1);
                        a_base_n = a_base + ADDR_W'(k_dim);
                        b_base_n = ADDR_W'(1);
                    end else begin
                        j_cnt_n  = j_cnt + DIM_W'(1);
                        b_base_n = b_base + ADDR_W'(k_dim);
                    end
                    state_n   = S_RUN;
                    a_raddr_n = a_base_n;
                    b_raddr_n = b_base_n;
                end
            end

            S_DONE: begin
                state_n       = S_IDLE;
                start_ready_n = 1'b1;
            end

            default: begin
                state_n       = S_IDLE;
                start_ready_n = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: per-cycle expectations are derived
// from the run timeline (HDR, then K+2 cycles per element, then DONE).
module tb_matmul_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] a_raddr, b_raddr, res_waddr;
    logic [31:0] a_rdata_hdr, b_rdata_hdr;
    logic        mac_clear, mac_acc_en, res_we, done, err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];

    matmul_sequencer #(.ADDR_W(16), .DIM_W(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_raddr     (a_raddr),
        .b_raddr     (b_raddr),
        .a_rdata_hdr (a_rdata_hdr),
        .b_rdata_hdr (b_rdata_hdr),
        .mac_clear   (mac_clear),
        .mac_acc_en  (mac_acc_en),
        .res_we      (res_we),
        .res_waddr   (res_waddr),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency SRAM models
    always @(posedge clk) begin
        a_rdata_hdr <= a_mem[a_raddr[7:0]];
        b_rdata_hdr <= b_mem[b_raddr[7:0]];
    end

    function automatic logic [37:0] observed();
        return {start_ready, a_raddr, b_raddr, mac_clear, mac_acc_en, res_we, done, err};
    endfunction

    task automatic check_reset_vals(input string tag);
        logic [37:0] ex;
        ex = {1'b1, 16'd0, 16'd0, 5'b00000};
        checks++;
        assert (observed() === ex) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed(), ex);
        end
        checks++;
        assert (res_waddr === 16'd0) else begin
            failures++;
            $error("FAIL %s_waddr observed=%0d expected=0", tag, res_waddr);
        end
    endtask

    // c = number of clock edges since the accepting edge (0 = HDR cycle)
    task automatic check_cycle(input string tag, input int c, input int m, input int k,
                               input int n, input bit valid);
        logic [37:0] ex;
        bit sr, clr, acc, we, dn, er;
        int ea, eb, ewa, t, p, e, q, i, j;
        sr = 0; clr = 0; acc = 0; we = 0; dn = 0; er = 0;
        ea = 0; eb = 0; ewa = 0;
        if (!valid) begin
            er = (c >= 1);
            dn = (c == 1);
            sr = (c >= 2);
        end else begin
            t = m * n * (k + 2);
            if (c >= 1 && c <= t) begin
                p = c - 1;
                e = p / (k + 2);
                q = p % (k + 2);
                i = e / n;
                j = e % n;
                if (q < k) begin
                    ea = 1 + i * k + q;
                    eb = 1 + j * k + q;
                end
                if (q >= 1 && q <= k) begin
                    acc = 1;
                    clr = (q == 1);
                end
                if (q == k + 1) begin
                    we  = 1;
                    ewa = e;
                end
            end
            dn = (c == t + 1);
            sr = (c >= t + 2);
        end
        ex = {sr, 16'(ea), 16'(eb), clr, acc, we, dn, er};
        checks++;
        assert (observed() === ex) else begin
            failures++;
            $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, observed(), ex);
        end
        if (we) begin
            checks++;
            assert (res_waddr === 16'(ewa)) else begin
                failures++;
                $error("FAIL %s_waddr c=%0d observed=%0d expected=%0d", tag, c, res_waddr, ewa);
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
    task automatic run_op(input string tag, input int m, input int k, input int kb,
                          input int n, input bit hold);
        bit valid;
        int last;
        valid = (m != 0) && (k != 0) && (n != 0) && (kb == k);
        last  = valid ? (m * n * (k + 2) + 2) : 2;
        a_mem[0] = {16'(m), 16'(k)};
        b_mem[0] = {16'(kb), 16'(n)};
        checks++;
        assert (start_ready === 1'b1) else begin
            failures++;
            $error("FAIL %s_ready observed=%b expected=1", tag, start_ready);
        end
        start_valid = 1'b1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) start_valid = 1'b0;
            check_cycle(tag, c, m, k, n, valid);
        end
        if (!hold) start_valid = 1'b0;
    endtask

    initial begin
        int m, k, kb, n;
        bit hold;
        for (int a = 0; a < 256; a++) begin
            a_mem[a] = $urandom;
            b_mem[a] = $urandom;
        end
        reset_n     = 1'b0;
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset_idle");

        run_op("mm_2x3x2", 2, 3, 3, 2, 0);
        run_op("mm_1x1x1", 1, 1, 1, 1, 0);
        run_op("k_mismatch", 2, 3, 4, 2, 0);
        for (int x = 0; x < 3; x++) begin
            @(negedge clk);
            check_cycle("err_hold", 3 + x, 2, 3, 2, 0);
        end
        run_op("clear_err", 1, 2, 2, 1, 0);
        run_op("m_zero", 0, 3, 3, 2, 0);

        // Reset during RUN of element (0,1) of a 2x3x2 run
        a_mem[0] = {16'd2, 16'd3};
        b_mem[0] = {16'd3, 16'd2};
        start_valid = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c == 0) start_valid = 1'b0;
            check_cycle("pre_abort", c, 2, 3, 2, 1);
        end
        #1 reset_n = 1'b0;
        #1 check_reset_vals("abort_async");
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("abort_hold");
        end
        reset_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check_reset_vals("abort_idle");
        end

        // start_valid held high across back-to-back runs
        run_op("hold_run1", 2, 2, 2, 2, 1);
        run_op("hold_run2", 2, 2, 2, 2, 0);

        for (int r = 0; r < 14; r++) begin
            m    = $urandom_range(1, 4);
            k    = $urandom_range(1, 4);
            n    = $urandom_range(1, 4);
            kb   = k;
            hold = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: kb = k + 1;
                1: n  = 0;
                default: ;
            endcase
            run_op("random", m, k, kb, n, hold);
        end
        start_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
